// File: rtl/cw305_loader_pkg.sv
// Shared types for the CW305 instruction loader: entry kinds, the queued
// entry layout and the output FSM states.
package cw305_loader_pkg;

    typedef enum logic {
        KIND_INSTR = 1'b0,
        KIND_ADDR  = 1'b1
    } entry_kind_e;

    typedef struct packed {
        entry_kind_e kind;
        logic [31:0] data;
    } loader_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        GAP
    } loader_state_e;

endpackage

// File: rtl/loader_fifo.sv
// Synchronous FIFO of loader entries. The head is read straight from the
// storage flops, so it is stable for as long as no pop occurs.
module loader_fifo
    import cw305_loader_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH = 8,
    localparam int unsigned LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               push_i,
    input  loader_entry_t      push_data_i,
    input  logic               pop_i,
    output loader_entry_t      head_o,
    output logic               full_o,
    output logic               empty_o,
    output logic [LEVEL_W-1:0] level_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    loader_entry_t      mem_q [FIFO_DEPTH];
    loader_entry_t      mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               do_push;
    logic               do_pop;

    assign full_o  = (level_q == LEVEL_W'(FIFO_DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only accepted when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + LEVEL_W'(1);
                2'b01:   level_d = level_q - LEVEL_W'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/cw305_instr_loader.sv
// Assembles host bytes into little-endian 32-bit words, queues them in order
// and hands them one at a time to the OBI bridge using its valid/reset-valid handshake.
module cw305_instr_loader
    import cw305_loader_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH = 8,
    localparam int unsigned LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clear_i,
    input  logic               byte_valid_i,
    input  logic [7:0]         byte_i,
    input  logic               byte_kind_i,
    output logic               inst_valid_o,
    output logic [31:0]        instruction_o,
    output logic               new_addr_valid_o,
    output logic [31:0]        new_section_address_o,
    input  logic               busy_i,
    input  logic               rst_instr_valid_i,
    input  logic               rst_new_addr_valid_i,
    output logic [LEVEL_W-1:0] fifo_level_o,
    output logic               fifo_full_o,
    output logic               overflow_o,
    output logic               kind_err_o,
    output logic               idle_o
);

    loader_state_e state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic [23:0]   buf_q, buf_d;
    entry_kind_e   kind_q, kind_d;
    logic          inst_valid_q, inst_valid_d;
    logic [31:0]   instr_q, instr_d;
    logic          addr_valid_q, addr_valid_d;
    logic [31:0]   addr_q, addr_d;
    logic          overflow_q, overflow_d;
    logic          kind_err_q, kind_err_d;

    entry_kind_e   byte_kind;
    logic          push;
    loader_entry_t push_data;
    logic          pop;
    logic          ack_match;
    loader_entry_t head;
    logic          fifo_full;
    logic          fifo_empty;

    assign byte_kind = entry_kind_e'(byte_kind_i);
    assign ack_match = (head.kind == KIND_INSTR) ? rst_instr_valid_i : rst_new_addr_valid_i;

    loader_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level_o)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        buf_d        = buf_q;
        kind_d       = kind_q;
        inst_valid_d = inst_valid_q;
        instr_d      = instr_q;
        addr_valid_d = addr_valid_q;
        addr_d       = addr_q;
        overflow_d   = overflow_q;
        kind_err_d   = kind_err_q;
        push         = 1'b0;
        push_data    = '0;
        pop          = 1'b0;

        if (clear_i) begin
            cnt_d        = 2'd0;
            overflow_d   = 1'b0;
            kind_err_d   = 1'b0;
            inst_valid_d = 1'b0;
            addr_valid_d = 1'b0;
            state_d      = IDLE;
        end else begin
            if (byte_valid_i) begin
                // A kind switch mid-word abandons the partial word and restarts with this byte.
                if (cnt_q != 2'd0 && byte_kind != kind_q) begin
                    kind_err_d = 1'b1;
                    buf_d[7:0] = byte_i;
                    kind_d     = byte_kind;
                    cnt_d      = 2'd1;
                end else begin
                    case (cnt_q)
                        2'd0: begin
                            buf_d[7:0] = byte_i;
                            kind_d     = byte_kind;
                            cnt_d      = 2'd1;
                        end
                        2'd1: begin
                            buf_d[15:8] = byte_i;
                            cnt_d       = 2'd2;
                        end
                        2'd2: begin
                            buf_d[23:16] = byte_i;
                            cnt_d        = 2'd3;
                        end
                        default: begin
                            push           = 1'b1;
                            push_data.kind = byte_kind;
                            push_data.data = {byte_i, buf_q};
                            cnt_d          = 2'd0;
                        end
                    endcase
                end
            end

            case (state_q)
                IDLE: begin
                    if (!fifo_empty && !busy_i) begin
                        state_d = PRESENT;
                        if (head.kind == KIND_INSTR) begin
                            inst_valid_d = 1'b1;
                            instr_d      = head.data;
                        end else begin
                            addr_valid_d = 1'b1;
                            addr_d       = head.data;
                        end
                    end
                end
                PRESENT: begin
                    if (ack_match) begin
                        inst_valid_d = 1'b0;
                        addr_valid_d = 1'b0;
                        pop          = 1'b1;
                        state_d      = GAP;
                    end
                end
                GAP:     state_d = IDLE;
                default: state_d = IDLE;
            endcase

            if (push && fifo_full && !pop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            buf_q        <= '0;
            kind_q       <= KIND_INSTR;
            inst_valid_q <= 1'b0;
            instr_q      <= '0;
            addr_valid_q <= 1'b0;
            addr_q       <= '0;
            overflow_q   <= 1'b0;
            kind_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            buf_q        <= buf_d;
            kind_q       <= kind_d;
            inst_valid_q <= inst_valid_d;
            instr_q      <= instr_d;
            addr_valid_q <= addr_valid_d;
            addr_q       <= addr_d;
            overflow_q   <= overflow_d;
            kind_err_q   <= kind_err_d;
        end
    end

    assign inst_valid_o          = inst_valid_q;
    assign instruction_o         = instr_q;
    assign new_addr_valid_o      = addr_valid_q;
    assign new_section_address_o = addr_q;
    assign fifo_full_o           = fifo_full;
    assign overflow_o            = overflow_q;
    assign kind_err_o            = kind_err_q;
    assign idle_o                = fifo_empty && (cnt_q == 2'd0) && (state_q == IDLE);

endmodule

// File: tb/tb_cw305_instr_loader.sv
// Directed bench for cw305_instr_loader: byte assembly, ordered presentation,
// overflow, kind errors, busy gating, clear and asynchronous reset.
module tb_cw305_instr_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        byte_valid;
    logic [7:0]  byte_d;
    logic        byte_kind;
    logic        inst_valid;
    logic [31:0] instruction;
    logic        addr_valid;
    logic [31:0] address;
    logic        busy;
    logic        ack_instr;
    logic        ack_addr;
    logic [3:0]  level;
    logic        full;
    logic        overflow;
    logic        kind_err;
    logic        idle;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    cw305_instr_loader #(.FIFO_DEPTH(8)) dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .clear_i               (clear),
        .byte_valid_i          (byte_valid),
        .byte_i                (byte_d),
        .byte_kind_i           (byte_kind),
        .inst_valid_o          (inst_valid),
        .instruction_o         (instruction),
        .new_addr_valid_o      (addr_valid),
        .new_section_address_o (address),
        .busy_i                (busy),
        .rst_instr_valid_i     (ack_instr),
        .rst_new_addr_valid_i  (ack_addr),
        .fifo_level_o          (level),
        .fifo_full_o           (full),
        .overflow_o            (overflow),
        .kind_err_o            (kind_err),
        .idle_o                (idle)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic k);
        byte_valid = 1'b1;
        byte_d     = b;
        byte_kind  = k;
        step();
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic k);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], k);
    endtask

    task automatic pulse_ack_instr();
        ack_instr = 1'b1;
        step();
        ack_instr = 1'b0;
    endtask

    task automatic pulse_ack_addr();
        ack_addr = 1'b1;
        step();
        ack_addr = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            if (inst_valid || addr_valid) ok = 1'b1;
            else step();
        end
    endtask

    function automatic logic [31:0] ovf_word(input int i);
        return {8'(i), 8'hC3, 8'h3C, 8'(i + 16)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL reset_inst_valid: got %b want 0", inst_valid); else n_pass++;
        n_checks++; if (addr_valid !== 1'b0) $display("FAIL reset_addr_valid: got %b want 0", addr_valid); else n_pass++;
        n_checks++; if (instruction !== 32'h0) $display("FAIL reset_instruction: got %h want 0", instruction); else n_pass++;
        n_checks++; if (address !== 32'h0) $display("FAIL reset_address: got %h want 0", address); else n_pass++;
        n_checks++; if (level !== 4'd0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
        n_checks++; if ({full, overflow, kind_err} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {full, overflow, kind_err}); else n_pass++;
        n_checks++; if (idle !== 1'b1) $display("FAIL reset_idle: got %b want 1", idle); else n_pass++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        send_word(32'h00100513, 1'b0);
        n_checks++; if (level !== 4'd1) $display("FAIL basic_level_push: got %0d want 1", level); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL basic_valid_early: got %b want 0", inst_valid); else n_pass++;
        n_checks++; if (idle !== 1'b0) $display("FAIL basic_idle_busy: got %b want 0", idle); else n_pass++;
        step();
        n_checks++; if (inst_valid !== 1'b1 || instruction !== 32'h00100513) $display("FAIL basic_present: got v=%b d=%h want v=1 d=00100513", inst_valid, instruction); else n_pass++;
        step();
        n_checks++; if (inst_valid !== 1'b1) $display("FAIL basic_hold: got %b want 1", inst_valid); else n_pass++;
        pulse_ack_instr();
        n_checks++; if (inst_valid !== 1'b0 || level !== 4'd0) $display("FAIL basic_after_ack: got v=%b lvl=%0d want v=0 lvl=0", inst_valid, level); else n_pass++;
        n_checks++; if (instruction !== 32'h00100513) $display("FAIL basic_data_kept: got %h want 00100513", instruction); else n_pass++;
        step();
        n_checks++; if (idle !== 1'b1) $display("FAIL basic_idle_back: got %b want 1", idle); else n_pass++;
    endtask

    task automatic test_order();
        send_word(32'h00000100, 1'b1);
        send_word(32'h00000013, 1'b0);
        n_checks++; if (addr_valid !== 1'b1 || address !== 32'h00000100) $display("FAIL order_addr_first: got v=%b d=%h want v=1 d=00000100", addr_valid, address); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0 || level !== 4'd2) $display("FAIL order_inst_wait: got v=%b lvl=%0d want v=0 lvl=2", inst_valid, level); else n_pass++;
        pulse_ack_instr();
        n_checks++; if (addr_valid !== 1'b1 || level !== 4'd2) $display("FAIL order_wrong_ack: got v=%b lvl=%0d want v=1 lvl=2", addr_valid, level); else n_pass++;
        pulse_ack_addr();
        n_checks++; if (addr_valid !== 1'b0 || inst_valid !== 1'b0 || level !== 4'd1) $display("FAIL order_ack_addr: got av=%b iv=%b lvl=%0d want 0 0 1", addr_valid, inst_valid, level); else n_pass++;
        step();
        n_checks++; if (inst_valid !== 1'b0) $display("FAIL order_gap: got %b want 0", inst_valid); else n_pass++;
        step();
        n_checks++; if (inst_valid !== 1'b1 || instruction !== 32'h00000013) $display("FAIL order_inst: got v=%b d=%h want v=1 d=00000013", inst_valid, instruction); else n_pass++;
        pulse_ack_instr();
        step();
    endtask

    task automatic test_overflow();
        bit ok;
        for (int i = 1; i <= 9; i++) begin
            send_word(ovf_word(i), 1'b0);
            if (i == 8) begin
                n_checks++; if (full !== 1'b1 || overflow !== 1'b0) $display("FAIL ovf_full8: got f=%b o=%b want f=1 o=0", full, overflow); else n_pass++;
            end
        end
        n_checks++; if (full !== 1'b1 || overflow !== 1'b1 || level !== 4'd8) $display("FAIL ovf_9th: got f=%b o=%b lvl=%0d want 1 1 8", full, overflow, level); else n_pass++;
        for (int i = 1; i <= 8; i++) begin
            wait_valid(ok);
            n_checks++; if (!ok || inst_valid !== 1'b1 || instruction !== ovf_word(i)) $display("FAIL ovf_drain_%0d: got ok=%b d=%h want %h", i, ok, instruction, ovf_word(i)); else n_pass++;
            pulse_ack_instr();
        end
        repeat (6) step();
        n_checks++; if (inst_valid !== 1'b0 || level !== 4'd0 || overflow !== 1'b1) $display("FAIL ovf_end: got v=%b lvl=%0d o=%b want 0 0 1", inst_valid, level, overflow); else n_pass++;
    endtask

    task automatic test_kind_err();
        bit ok;
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_checks++; if (overflow !== 1'b0) $display("FAIL kerr_clear_ovf: got %b want 0", overflow); else n_pass++;
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'h78, 1'b1);
        n_checks++; if (kind_err !== 1'b1 || level !== 4'd0) $display("FAIL kerr_set: got e=%b lvl=%0d want 1 0", kind_err, level); else n_pass++;
        send_byte(8'h56, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h12, 1'b1);
        n_checks++; if (level !== 4'd1) $display("FAIL kerr_level: got %0d want 1", level); else n_pass++;
        wait_valid(ok);
        n_checks++; if (!ok || addr_valid !== 1'b1 || inst_valid !== 1'b0 || address !== 32'h12345678) $display("FAIL kerr_entry: got ok=%b av=%b iv=%b d=%h want 1 1 0 12345678", ok, addr_valid, inst_valid, address); else n_pass++;
        pulse_ack_addr();
        step();
    endtask

    task automatic test_busy();
        busy = 1'b1;
        send_word(32'hDEADBEEF, 1'b0);
        repeat (4) step();
        n_checks++; if (inst_valid !== 1'b0 || addr_valid !== 1'b0 || level !== 4'd1) $display("FAIL busy_hold: got iv=%b av=%b lvl=%0d want 0 0 1", inst_valid, addr_valid, level); else n_pass++;
        busy = 1'b0;
        step();
        n_checks++; if (inst_valid !== 1'b1 || instruction !== 32'hDEADBEEF) $display("FAIL busy_release: got v=%b d=%h want v=1 d=deadbeef", inst_valid, instruction); else n_pass++;
        pulse_ack_addr();
        n_checks++; if (inst_valid !== 1'b1 || level !== 4'd1) $display("FAIL busy_wrong_ack: got v=%b lvl=%0d want 1 1", inst_valid, level); else n_pass++;
        pulse_ack_instr();
        n_checks++; if (inst_valid !== 1'b0 || level !== 4'd0) $display("FAIL busy_ack: got v=%b lvl=%0d want 0 0", inst_valid, level); else n_pass++;
        step();
    endtask

    task automatic test_clear();
        bit ok;
        for (int i = 1; i <= 9; i++) send_word(ovf_word(i), 1'b0);
        for (int i = 1; i <= 5; i++) begin
            wait_valid(ok);
            pulse_ack_instr();
        end
        wait_valid(ok);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b1);
        n_checks++; if (!ok || inst_valid !== 1'b1 || level !== 4'd3 || overflow !== 1'b1 || kind_err !== 1'b1) $display("FAIL clr_pre: got ok=%b v=%b lvl=%0d o=%b e=%b want 1 1 3 1 1", ok, inst_valid, level, overflow, kind_err); else n_pass++;
        clear      = 1'b1;
        byte_valid = 1'b1;
        byte_d     = 8'h99;
        byte_kind  = 1'b0;
        ack_instr  = 1'b1;
        step();
        clear      = 1'b0;
        byte_valid = 1'b0;
        ack_instr  = 1'b0;
        n_checks++; if (inst_valid !== 1'b0 || level !== 4'd0) $display("FAIL clr_flush: got v=%b lvl=%0d want 0 0", inst_valid, level); else n_pass++;
        n_checks++; if (overflow !== 1'b0 || kind_err !== 1'b0 || idle !== 1'b1) $display("FAIL clr_flags: got o=%b e=%b idle=%b want 0 0 1", overflow, kind_err, idle); else n_pass++;
        n_checks++; if (instruction !== ovf_word(6)) $display("FAIL clr_data_kept: got %h want %h", instruction, ovf_word(6)); else n_pass++;
        repeat (4) step();
        n_checks++; if (inst_valid !== 1'b0 || level !== 4'd0) $display("FAIL clr_quiet: got v=%b lvl=%0d want 0 0", inst_valid, level); else n_pass++;
    endtask

    task automatic test_async_reset();
        bit ok;
        send_word(32'hCAFEF00D, 1'b1);
        wait_valid(ok);
        n_checks++; if (!ok || addr_valid !== 1'b1 || address !== 32'hCAFEF00D) $display("FAIL arst_pre: got ok=%b v=%b d=%h want 1 1 cafef00d", ok, addr_valid, address); else n_pass++;
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (addr_valid !== 1'b0 || address !== 32'h0 || level !== 4'd0) $display("FAIL arst_immediate: got v=%b d=%h lvl=%0d want 0 0 0", addr_valid, address, level); else n_pass++;
        n_checks++; if (idle !== 1'b1 || kind_err !== 1'b0 || overflow !== 1'b0) $display("FAIL arst_flags: got idle=%b e=%b o=%b want 1 0 0", idle, kind_err, overflow); else n_pass++;
        #1;
        rst_n = 1'b1;
        step();
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        n_checks++; if (level !== 4'd0) $display("FAIL arst_counter: got %0d want 0", level); else n_pass++;
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        wait_valid(ok);
        n_checks++; if (!ok || inst_valid !== 1'b1 || instruction !== 32'h66554433) $display("FAIL arst_word: got ok=%b v=%b d=%h want 1 1 66554433", ok, inst_valid, instruction); else n_pass++;
        pulse_ack_instr();
        step();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rst_n      = 1'b0;
        clear      = 1'b0;
        byte_valid = 1'b0;
        byte_d     = 8'h00;
        byte_kind  = 1'b0;
        busy       = 1'b0;
        ack_instr  = 1'b0;
        ack_addr   = 1'b0;
        test_reset();
        test_basic();
        test_order();
        test_overflow();
        test_kind_err();
        test_busy();
        test_clear();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
